// File: rtl/ufp_pkg.sv
// Shared types and helpers for the unsigned fixed-point sequential divider.
package ufp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cycles spent in RUN: one quotient bit per cycle for W+FRAC_W bits.
    function automatic int unsigned ufp_latency(input int unsigned int_w,
                                                input int unsigned frac_w);
        return int_w + 2 * frac_w;
    endfunction

endpackage

// File: rtl/ufp_div_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, subtract if possible.
module ufp_div_step #(
    parameter int unsigned W = 9
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] dvs_i,
    input  logic         bit_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W+1:0] rem_sh;
    logic [W+1:0] dvs_ext;

    always_comb begin
        rem_sh  = {rem_i, bit_i};
        dvs_ext = {2'b00, dvs_i};
        q_o     = (rem_sh >= dvs_ext);
        rem_o   = q_o ? (W+1)'(rem_sh - dvs_ext) : rem_sh[W:0];
    end

endmodule

// File: rtl/ufp_seq_div.sv
// Sequential unsigned fixed-point divider (INT_W.FRAC_W), one quotient bit per cycle,
// with optional round-half-up, saturation and divide-by-zero flagging.
module ufp_seq_div
    import ufp_pkg::*;
#(
    parameter int unsigned INT_W  = 1,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ROUND  = 0
) (
    input  logic                    iClk,
    input  logic                    iReset,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [INT_W+FRAC_W-1:0] iQ,
    input  logic [INT_W+FRAC_W-1:0] iD,
    output logic                    oValid,
    input  logic                    iReady,
    output logic [INT_W+FRAC_W-1:0] oR,
    output logic                    oOvf,
    output logic                    oDivZero
);

    localparam int unsigned W  = INT_W + FRAC_W;
    localparam int unsigned N  = ufp_latency(INT_W, FRAC_W);
    localparam int unsigned CW = $clog2(N + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W:0]      rem_q, rem_d;
    logic [N-2:0]    quot_q, quot_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    r_q, r_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;

    logic [W:0]      step_rem;
    logic            step_q;
    logic [N-1:0]    q_fin;
    logic            round_up;
    logic [N:0]      quot_rnd;
    logic            ovf_fin;

    ufp_div_step #(.W(W)) u_step (
        .rem_i (rem_q),
        .dvs_i (dvs_q),
        .bit_i (dvd_q[N-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        r_d      = r_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;

        // Final quotient/remainder as they stand after the current step.
        q_fin    = {quot_q, step_q};
        round_up = (ROUND == 1) && ({step_rem, 1'b0} >= {2'b00, dvs_q});
        quot_rnd = {1'b0, q_fin} + (N+1)'(round_up);
        ovf_fin  = |quot_rnd[N:W];

        case (state_q)
            IDLE: begin
                if (iValid) begin
                    dvs_d   = iD;
                    dvd_d   = {iQ, FRAC_W'(0)};
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = CW'(N);
                    ready_d = 1'b0;
                    if (iD == '0) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        r_d     = '1;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d  = step_rem;
                quot_d = q_fin[N-2:0];
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    ovf_d   = ovf_fin;
                    r_d     = ovf_fin ? '1 : quot_rnd[W-1:0];
                    dz_d    = 1'b0;
                end
            end
            DONE: begin
                if (iReady) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign oReady   = ready_q;
    assign oValid   = valid_q;
    assign oR       = r_q;
    assign oOvf     = ovf_q;
    assign oDivZero = dz_q;

endmodule

// File: tb/tb_ufp_seq_div.sv
// Scoreboard bench for ufp_seq_div: truncating and rounding instances share one stimulus stream.
module tb_ufp_seq_div;

    logic       iClk = 1'b0;
    logic       iReset, iValid, iReady;
    logic [8:0] iQ, iD;
    logic       oReady0, oValid0, oOvf0, oDivZero0;
    logic       oReady1, oValid1, oOvf1, oDivZero1;
    logic [8:0] oR0, oR1;

    ufp_seq_div #(.INT_W(1), .FRAC_W(8), .ROUND(0)) dut0 (
        .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady0),
        .iQ(iQ), .iD(iD), .oValid(oValid0), .iReady(iReady),
        .oR(oR0), .oOvf(oOvf0), .oDivZero(oDivZero0)
    );

    ufp_seq_div #(.INT_W(1), .FRAC_W(8), .ROUND(1)) dut1 (
        .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady1),
        .iQ(iQ), .iD(iD), .oValid(oValid1), .iReady(iReady),
        .oR(oR1), .oOvf(oOvf1), .oDivZero(oDivZero1)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] r;
        logic       ovf;
        logic       dz;
        int         lat;
        int         hs;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   nerr = 0;
    int   nchk = 0;
    logic pv0 = 1'b0;
    logic pv1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare one delivered result against the oldest expected entry for that instance.
    task automatic mon(input int k, input logic [8:0] r, input logic ovf, input logic dz);
        exp_t e;
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_valid dut%0d: got oValid=1 expected 0", k);
            return;
        end
        if (k == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        chk($sformatf("oR dut%0d", k), 32'(r), 32'(e.r));
        chk($sformatf("oOvf dut%0d", k), 32'(ovf), 32'(e.ovf));
        chk($sformatf("oDivZero dut%0d", k), 32'(dz), 32'(e.dz));
        chk($sformatf("latency dut%0d", k), 32'(cyc - e.hs), 32'(e.lat));
    endtask

    always @(negedge iClk) begin
        if (oValid0 && !pv0) mon(0, oR0, oOvf0, oDivZero0);
        if (oValid1 && !pv1) mon(1, oR1, oOvf1, oDivZero1);
        pv0 = oValid0;
        pv1 = oValid1;
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge iClk);
            if (oReady0 && oReady1) return;
        end
        nchk++;
        nerr++;
        $display("FAIL idle_timeout: got oReady=0 expected 1");
    endtask

    // Issue one operand pair; hs is the cycle number of the handshake cycle.
    task automatic send(input logic [8:0] q, input logic [8:0] d,
                        input logic [8:0] r0, input logic [8:0] r1,
                        input logic ovf, input logic dz, input int lat,
                        input bit push, output int hs);
        exp_t e;
        wait_idle();
        @(posedge iClk);
        #1;
        iValid = 1'b1;
        iQ     = q;
        iD     = d;
        @(negedge iClk);
        chk("hs_oReady", 32'(oReady0 & oReady1), 32'd1);
        hs = cyc;
        if (push) begin
            e.r = r0; e.ovf = ovf; e.dz = dz; e.lat = lat; e.hs = hs;
            sb0.push_back(e);
            e.r = r1;
            sb1.push_back(e);
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iQ     = 9'($urandom);
        iD     = 9'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        iReset = 1'b1;
        iValid = 1'b0;
        iReady = 1'b1;
        iQ     = '0;
        iD     = '0;
        #3;
        chk("rst_ready",  32'({oReady0, oReady1}), 32'b11);
        chk("rst_valid",  32'({oValid0, oValid1}), 32'b00);
        chk("rst_oR",     32'({oR0, oR1}), 32'h0);
        chk("rst_flags",  32'({oOvf0, oDivZero0, oOvf1, oDivZero1}), 32'h0);
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;

        send(9'h100, 9'h100, 9'h100, 9'h100, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h080, 9'h100, 9'h080, 9'h080, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h100, 9'h080, 9'h1FF, 9'h1FF, 1'b1, 1'b0, 18, 1'b1, hs);
        send(9'h002, 9'h003, 9'h0AA, 9'h0AB, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h001, 9'h003, 9'h055, 9'h055, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h005, 9'h003, 9'h1AA, 9'h1AB, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h0FF, 9'h000, 9'h1FF, 9'h1FF, 1'b0, 1'b1, 1,  1'b1, hs);
        send(9'h1FF, 9'h1FF, 9'h100, 9'h100, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h0C0, 9'h180, 9'h080, 9'h080, 1'b0, 1'b0, 18, 1'b1, hs);
        send(9'h1FF, 9'h001, 9'h1FF, 9'h1FF, 1'b1, 1'b0, 18, 1'b1, hs);
        send(9'h000, 9'h005, 9'h000, 9'h000, 1'b0, 1'b0, 18, 1'b1, hs);

        // Back-pressure in DONE plus stray iValid pulses while running.
        send(9'h100, 9'h100, 9'h100, 9'h100, 1'b0, 1'b0, 18, 1'b1, hs);
        iReady = 1'b0;
        @(posedge iClk); #1;
        iValid = 1'b1; iQ = 9'h0FF; iD = 9'h000;
        @(posedge iClk); #1;
        iQ = 9'h001; iD = 9'h003;
        @(posedge iClk); #1;
        iValid = 1'b0;
        for (int i = 0; i < 40 && !oValid0; i++) @(negedge iClk);
        chk("stall_valid_seen", 32'({oValid0, oValid1}), 32'b11);
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            chk("stall_oR0", 32'(oR0), 32'h100);
            chk("stall_oR1", 32'(oR1), 32'h100);
            chk("stall_flags", 32'({oValid0, oReady0, oOvf0, oDivZero0,
                                    oValid1, oReady1, oOvf1, oDivZero1}), 32'b1000_1000);
        end
        @(posedge iClk); #1;
        iReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        chk("release_idle", 32'({oReady0, oValid0, oReady1, oValid1}), 32'b1010);

        // Asynchronous reset in the middle of RUN discards the operation.
        send(9'h100, 9'h100, 9'h100, 9'h100, 1'b0, 1'b0, 18, 1'b0, hs);
        while (cyc < hs + 7) begin
            @(posedge iClk);
            #1;
        end
        #2;
        iReset = 1'b1;
        #1;
        chk("midrun_rst_ready", 32'({oReady0, oReady1}), 32'b11);
        chk("midrun_rst_valid", 32'({oValid0, oValid1}), 32'b00);
        chk("midrun_rst_out",   32'({oR0, oR1, oOvf0, oDivZero0, oOvf1, oDivZero1}), 32'h0);
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
        repeat (25) @(negedge iClk);
        chk("post_rst_no_valid", 32'({oValid0, oValid1}), 32'b00);
        send(9'h002, 9'h003, 9'h0AA, 9'h0AB, 1'b0, 1'b0, 18, 1'b1, hs);

        wait_idle();
        repeat (3) @(negedge iClk);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
